// File: rtl/sint_block_avg_ashr.sv
// Streaming signed block averager: sums blocks of 2**LOG2N signed samples and emits
// floor(sum / N) via an arithmetic shift, one WIDTH-bit result per block.
module sint_block_avg_ashr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOG2N = 2
) (
    input  logic                    CLK,
    input  logic                    ASYNCRESETN,
    input  logic                    clear,
    input  logic                    I_valid,
    output logic                    I_ready,
    input  logic signed [WIDTH-1:0] I,
    output logic                    O_valid,
    input  logic                    O_ready,
    output logic signed [WIDTH-1:0] O
);

    localparam int unsigned ACC_W = WIDTH + LOG2N;
    localparam int unsigned N     = 1 << LOG2N;
    // Keep the counter at least one bit wide so LOG2N=0 still elaborates cleanly.
    localparam int unsigned CNT_W = (LOG2N > 0) ? LOG2N : 1;

    typedef enum logic [0:0] {
        StAccum,
        StHold
    } state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [WIDTH-1:0]   o_q, o_d;

    logic                      accept;
    logic                      last;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [WIDTH-1:0]   result;

    // Handshake signals; I_ready depends only on state and O_ready.
    always_comb begin
        I_ready = (state_q == StAccum) ? 1'b1 : O_ready;
        O_valid = (state_q == StHold);
        O       = o_q;
        accept  = I_valid & I_ready;
        if (LOG2N == 0) begin
            last = accept;
        end else begin
            last = accept & (cnt_q == CNT_W'(N - 1));
        end
    end

    // Widened sum and floor-divided result; the accumulator width makes both lossless.
    always_comb begin
        sample_ext = I;
        sum        = acc_q + sample_ext;
        shifted    = sum >>> LOG2N;
        result     = shifted[WIDTH-1:0];
    end

    // Next-state logic: clear has top priority and discards any handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        if (clear) begin
            state_d = StAccum;
            acc_d   = '0;
            cnt_d   = '0;
            o_d     = '0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (last) begin
                        o_d     = result;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StHold;
                    end else if (accept) begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    if (O_ready) begin
                        if (last) begin
                            // Only reachable with LOG2N=0: back-to-back results.
                            o_d = result;
                        end else if (accept) begin
                            acc_d   = sample_ext;
                            cnt_d   = CNT_W'(1);
                            state_d = StAccum;
                        end else begin
                            state_d = StAccum;
                        end
                    end
                end
                default: begin
                    state_d = StAccum;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

endmodule

// File: tb/tb_sint_block_avg_ashr.sv
// Directed bench for sint_block_avg_ashr: LOG2N=2 instance plus a LOG2N=0 instance.
module tb_sint_block_avg_ashr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    logic              iv, ir, ov, ordy;
    logic signed [7:0] din, dout;
    logic              iv0, ir0, ov0, ordy0;
    logic signed [7:0] din0, dout0;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    sint_block_avg_ashr #(.WIDTH(8), .LOG2N(2)) dut (
        .CLK        (clk),
        .ASYNCRESETN(rst_n),
        .clear      (clear),
        .I_valid    (iv),
        .I_ready    (ir),
        .I          (din),
        .O_valid    (ov),
        .O_ready    (ordy),
        .O          (dout)
    );

    sint_block_avg_ashr #(.WIDTH(8), .LOG2N(0)) dut0 (
        .CLK        (clk),
        .ASYNCRESETN(rst_n),
        .clear      (clear),
        .I_valid    (iv0),
        .I_ready    (ir0),
        .I          (din0),
        .O_valid    (ov0),
        .O_ready    (ordy0),
        .O          (dout0)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and clock it in.
    task automatic push(input logic signed [7:0] v);
        iv  = 1'b1;
        din = v;
        tick();
    endtask

    initial begin
        iv = 1'b0; din = '0; ordy = 1'b1;
        iv0 = 1'b0; din0 = '0; ordy0 = 1'b1;
        #12;
        check("rst_ovalid", ov, 0);
        check("rst_o", dout, 0);
        rst_n = 1'b1;
        #1;
        check("rst_iready", ir, 1);
        tick();

        // 1: 3,5,-2,6 -> 3
        push(8'sd3);
        check("t1_iready0", ir, 1);
        check("t1_ovalid0", ov, 0);
        push(8'sd5);
        push(-8'sd2);
        check("t1_ovalid2", ov, 0);
        push(8'sd6);
        check("t1_ovalid", ov, 1);
        check("t1_o", dout, 3);
        check("t1_iready", ir, 1);
        iv = 1'b0;
        tick();
        check("t1_ovalid_drop", ov, 0);

        // 2: -1,-1,-1,-2 -> floor(-5/4) = -2
        push(-8'sd1);
        push(-8'sd1);
        push(-8'sd1);
        push(-8'sd2);
        check("t2_ovalid", ov, 1);
        check("t2_o", dout, -2);

        // 3: back-to-back extremes, first sample taken while the -2 result is consumed
        push(-8'sd128);
        check("t3_nobubble", ov, 0);
        push(-8'sd128);
        push(-8'sd128);
        push(-8'sd128);
        check("t3_min_valid", ov, 1);
        check("t3_min", dout, -128);
        push(8'sd127);
        push(8'sd127);
        push(8'sd127);
        push(8'sd127);
        check("t3_max_valid", ov, 1);
        check("t3_max", dout, 127);
        iv = 1'b0;
        tick();
        check("t3_drop", ov, 0);

        // 4: backpressure. 1,2,3,4 -> 2
        ordy = 1'b0;
        push(8'sd1);
        push(8'sd2);
        push(8'sd3);
        push(8'sd4);
        check("t4_o", dout, 2);
        iv = 1'b1; din = 8'sd10;
        for (int k = 0; k < 3; k++) begin
            check("t4_hold_valid", ov, 1);
            check("t4_hold_o", dout, 2);
            check("t4_hold_iready", ir, 0);
            tick();
        end
        ordy = 1'b1;
        #1;
        check("t4_release_iready", ir, 1);
        tick();
        check("t4_consumed", ov, 0);
        push(8'sd2);
        push(8'sd2);
        push(8'sd2);
        check("t4_next_valid", ov, 1);
        check("t4_next_o", dout, 4);
        iv = 1'b0;
        tick();

        // 5a: async reset mid-block
        push(8'sd7);
        push(8'sd9);
        iv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ovalid", ov, 0);
        check("t5_rst_o", dout, 0);
        rst_n = 1'b1;
        #1;
        check("t5_rst_iready", ir, 1);
        tick();
        push(8'sd1);
        push(8'sd1);
        push(8'sd1);
        push(8'sd1);
        check("t5_rst_valid", ov, 1);
        check("t5_rst_result", dout, 1);
        iv = 1'b0;
        tick();

        // 5b: synchronous clear mid-block, concurrent sample is discarded
        push(8'sd7);
        push(8'sd9);
        clear = 1'b1;
        push(8'sd100);
        clear = 1'b0;
        check("t5_clr_ovalid", ov, 0);
        check("t5_clr_o", dout, 0);
        push(8'sd1);
        push(8'sd1);
        push(8'sd1);
        check("t5_clr_partial", ov, 0);
        push(8'sd1);
        check("t5_clr_valid", ov, 1);
        check("t5_clr_result", dout, 1);
        iv = 1'b0;
        tick();

        // 6: LOG2N=0 streams one result per cycle
        iv0 = 1'b1; din0 = 8'sd5;
        tick();
        check("t6_v0", ov0, 1);
        check("t6_o0", dout0, 5);
        din0 = -8'sd3;
        tick();
        check("t6_v1", ov0, 1);
        check("t6_o1", dout0, -3);
        din0 = 8'sd4;
        tick();
        check("t6_v2", ov0, 1);
        check("t6_o2", dout0, 4);
        check("t6_iready", ir0, 1);
        iv0 = 1'b0;
        tick();
        check("t6_drop", ov0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
